uart_ctrl: RTL and testbench

Memory-mapped UART controller between the pipeline CPU's data-memory bus and the UART receiver/transmitter cores. It generates the shared 16x baud tick, buffers bytes in small TX and RX FIFOs, and sequences the transmitter core byte by byte. It also exposes a control/status register and raises an interrupt request toward the CPU's exception logic.

---
 rtl/uart_ctrl.sv | 162 ++++++++++++++++
 tb/tb_uart_ctrl.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_ctrl.sv
// Memory-mapped UART controller: baud tick generator, TX/RX byte FIFOs,
// transmitter sequencing FSM, control/status register and interrupt request.
module uart_ctrl #(
  parameter int unsigned CLK_HZ = 100000000,
  parameter int unsigned BAUD   = 9600,
  parameter int unsigned DEPTH  = 4
) (
  input  logic        sysclk,
  input  logic        reset,
  input  logic        mem_rd,
  input  logic        mem_wr,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        baud_tick,
  output logic        tx_start,
  output logic [7:0]  tx_data,
  input  logic        tx_busy,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic        irq
);

  localparam int unsigned DIV = CLK_HZ / (BAUD * 16);
  localparam int unsigned BW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int unsigned PW  = $clog2(DEPTH);
  localparam int unsigned CW  = PW + 1;

  localparam logic [31:0] ADDR_TXD = 32'h4000_0018;
  localparam logic [31:0] ADDR_RXD = 32'h4000_001C;
  localparam logic [31:0] ADDR_CON = 32'h4000_0020;

  typedef enum logic [1:0] {IDLE, START, ACK, DRAIN} tx_state_t;

  tx_state_t     state;
  logic [BW-1:0] baud_cnt;
  logic [7:0]    tx_mem [DEPTH];
  logic [7:0]    rx_mem [DEPTH];
  logic [PW-1:0] tx_wr, tx_rd, rx_wr, rx_rd;
  logic [CW-1:0] tx_count, rx_count;
  logic          tx_ie, rx_ie, rx_ovr, tx_ovf;

  logic tx_push_req, tx_pop, tx_full, tx_push_ok, tx_idle;
  logic rx_pop, rx_full, rx_ne, rx_push_ok;
  logic con_wr;
  logic [7:0]  rx_head;
  logic [31:0] con_val;
  logic unused_wdata;

  assign unused_wdata = ^wdata[31:8];

  // Baud divider: tick in the last cycle of each DIV-cycle period
  always_ff @(posedge sysclk) begin
    if (reset) begin
      baud_cnt <= '0;
    end else if (baud_cnt == BW'(DIV - 1)) begin
      baud_cnt <= '0;
    end else begin
      baud_cnt <= baud_cnt + BW'(1);
    end
  end

  assign baud_tick = (baud_cnt == BW'(DIV - 1));

  assign tx_push_req = mem_wr && (addr == ADDR_TXD);
  assign tx_pop      = (state == START);
  assign tx_full     = (tx_count == CW'(DEPTH));
  // A pop in the same cycle frees the slot, so a push into a full FIFO is kept
  assign tx_push_ok  = tx_push_req && (!tx_full || tx_pop);
  assign tx_idle     = (tx_count == '0) && (state == IDLE) && !tx_busy;

  assign rx_ne       = (rx_count != '0);
  assign rx_full     = (rx_count == CW'(DEPTH));
  assign rx_pop      = mem_rd && (addr == ADDR_RXD) && rx_ne;
  assign rx_push_ok  = rx_valid && (!rx_full || rx_pop);
  assign rx_head     = rx_ne ? rx_mem[rx_rd] : 8'h00;

  assign con_wr      = mem_wr && (addr == ADDR_CON);

  // FIFO storage needs no reset; pointers and counts define validity
  always_ff @(posedge sysclk) begin
    if (tx_push_ok) tx_mem[tx_wr] <= wdata[7:0];
    if (rx_push_ok) rx_mem[rx_wr] <= rx_data;
  end

  always_ff @(posedge sysclk) begin
    if (reset) begin
      tx_wr    <= '0;
      tx_rd    <= '0;
      tx_count <= '0;
      rx_wr    <= '0;
      rx_rd    <= '0;
      rx_count <= '0;
    end else begin
      if (tx_push_ok) tx_wr <= tx_wr + PW'(1);
      if (tx_pop)     tx_rd <= tx_rd + PW'(1);
      tx_count <= tx_count + CW'(tx_push_ok) - CW'(tx_pop);
      if (rx_push_ok) rx_wr <= rx_wr + PW'(1);
      if (rx_pop)     rx_rd <= rx_rd + PW'(1);
      rx_count <= rx_count + CW'(rx_push_ok) - CW'(rx_pop);
    end
  end

  // Control/status: sticky flags set on drops; a set in the same cycle wins over W1C
  always_ff @(posedge sysclk) begin
    if (reset) begin
      tx_ie  <= 1'b0;
      rx_ie  <= 1'b0;
      rx_ovr <= 1'b0;
      tx_ovf <= 1'b0;
    end else begin
      if (con_wr) begin
        tx_ie <= wdata[0];
        rx_ie <= wdata[1];
        if (wdata[5]) rx_ovr <= 1'b0;
        if (wdata[6]) tx_ovf <= 1'b0;
      end
      if (rx_valid && !rx_push_ok)  rx_ovr <= 1'b1;
      if (tx_push_req && !tx_push_ok) tx_ovf <= 1'b1;
    end
  end

  // Transmitter sequencing: one start pulse per byte, then follow tx_busy
  always_ff @(posedge sysclk) begin
    if (reset) begin
      state    <= IDLE;
      tx_start <= 1'b0;
      tx_data  <= 8'h00;
    end else begin
      tx_start <= 1'b0;
      case (state)
        IDLE: begin
          if ((tx_count != '0) && !tx_busy) begin
            state    <= START;
            tx_start <= 1'b1;
            tx_data  <= tx_mem[tx_rd];
          end
        end
        START: state <= ACK;
        ACK:   if (tx_busy)  state <= DRAIN;
        DRAIN: if (!tx_busy) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign con_val = {25'b0, tx_ovf, rx_ovr, tx_idle, tx_full, rx_ne, rx_ie, tx_ie};

  always_comb begin
    rdata = 32'h0;
    if (mem_rd) begin
      case (addr)
        ADDR_RXD: rdata = {24'b0, rx_head};
        ADDR_CON: rdata = con_val;
        default:  rdata = 32'h0;
      endcase
    end
  end

  assign irq = (rx_ie && rx_ne) || (tx_ie && tx_idle);

endmodule

// File: tb/tb_uart_ctrl.sv
// Directed bench for uart_ctrl: baud tick, TX sequencing and overflow,
// RX FIFO/overrun, interrupt and mid-transfer reset.
module tb_uart_ctrl;

  localparam logic [31:0] TXD = 32'h4000_0018;
  localparam logic [31:0] RXD = 32'h4000_001C;
  localparam logic [31:0] CON = 32'h4000_0020;

  logic        sysclk = 1'b0;
  logic        reset;
  logic        mem_rd, mem_wr;
  logic [31:0] addr, wdata, rdata;
  logic        baud_tick, tx_start, tx_busy, rx_valid, irq;
  logic [7:0]  tx_data, rx_data;

  int checks = 0;
  int errors = 0;
  int busy_len = 100;
  int busy_cnt = 0;
  bit busy_force = 1'b0;
  logic [7:0] starts[$];

  uart_ctrl dut (
    .sysclk(sysclk), .reset(reset), .mem_rd(mem_rd), .mem_wr(mem_wr),
    .addr(addr), .wdata(wdata), .rdata(rdata), .baud_tick(baud_tick),
    .tx_start(tx_start), .tx_data(tx_data), .tx_busy(tx_busy),
    .rx_valid(rx_valid), .rx_data(rx_data), .irq(irq)
  );

  always #5 sysclk = ~sysclk;

  // Transmitter core model: busy for busy_len cycles after each start pulse
  initial begin
    tx_busy = 1'b0;
    forever begin
      @(posedge sysclk);
      #1;
      if (reset) busy_cnt = 0;
      else if (tx_start) busy_cnt = busy_len;
      else if (busy_cnt > 0) busy_cnt--;
      tx_busy = busy_force || (busy_cnt > 0);
    end
  end

  // Log every transmitted byte
  initial begin
    forever begin
      @(negedge sysclk);
      if (tx_start === 1'b1) starts.push_back(tx_data);
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cpu_write(input logic [31:0] a, input logic [31:0] d);
    mem_wr = 1'b1; addr = a; wdata = d;
    @(negedge sysclk);
    mem_wr = 1'b0; addr = 32'h0; wdata = 32'h0;
  endtask

  task automatic cpu_read(input logic [31:0] a, output logic [31:0] d);
    mem_rd = 1'b1; addr = a;
    #1 d = rdata;
    @(negedge sysclk);
    mem_rd = 1'b0; addr = 32'h0;
  endtask

  task automatic rx_push(input logic [7:0] d);
    rx_valid = 1'b1; rx_data = d;
    @(negedge sysclk);
    rx_valid = 1'b0; rx_data = 8'h00;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(negedge sysclk);
    reset = 1'b0;
  endtask

  logic [31:0] rd;
  int ticks, t0, t1, waited;

  initial begin
    reset = 1'b1; mem_rd = 1'b0; mem_wr = 1'b0; addr = 32'h0; wdata = 32'h0;
    rx_valid = 1'b0; rx_data = 8'h00;
    @(negedge sysclk);
    @(negedge sysclk);
    check("reset_baud_tick", 32'(baud_tick), 32'h0);
    check("reset_tx_start", 32'(tx_start), 32'h0);
    check("reset_tx_data", 32'(tx_data), 32'h0);
    check("reset_irq", 32'(irq), 32'h0);

    // Baud tick after reset release
    reset = 1'b0;
    ticks = 0; t0 = -1; t1 = -1;
    for (int i = 1; i <= 1302; i++) begin
      @(negedge sysclk);
      if (baud_tick) begin
        if (ticks == 0) t0 = i; else if (ticks == 1) t1 = i;
        ticks++;
      end
    end
    check("baud_tick_count", 32'(ticks), 32'd2);
    check("baud_tick_first", 32'(t0), 32'd650);
    check("baud_tick_second", 32'(t1), 32'd1301);
    cpu_read(CON, rd);
    check("con_idle", rd, 32'h10);

    // Two bytes through the transmitter
    do_reset();
    starts.delete();
    busy_len = 100;
    cpu_write(TXD, 32'h55);
    check("start_latency_low", 32'(tx_start), 32'h0);
    cpu_write(TXD, 32'hAA);
    check("start_pulse", 32'(tx_start), 32'h1);
    check("start_data", 32'(tx_data), 32'h55);
    waited = 0;
    rd = 32'h0;
    while (!(starts.size() == 2 && rd[4]) && waited < 600) begin
      cpu_read(CON, rd);
      waited++;
    end
    check("tx_two_done_in_time", 32'(waited < 600), 32'h1);
    check("tx_pulse_count", 32'(starts.size()), 32'd2);
    if (starts.size() == 2) begin
      check("tx_byte0", 32'(starts[0]), 32'h55);
      check("tx_byte1", 32'(starts[1]), 32'hAA);
    end
    check("tx_idle_again", 32'(rd[4]), 32'h1);

    // Six writes with transmitter held busy: one in flight, four stored, one dropped
    do_reset();
    starts.delete();
    busy_len = 1000;
    for (int i = 1; i <= 6; i++) cpu_write(TXD, 32'(i));
    cpu_read(CON, rd);
    check("tx_ovf_set", rd, 32'h48);
    check("tx_inflight_count", 32'(starts.size()), 32'd1);
    if (starts.size() == 1) check("tx_inflight_byte", 32'(starts[0]), 32'h01);
    cpu_write(CON, 32'h40);
    cpu_read(CON, rd);
    check("tx_ovf_cleared", rd, 32'h08);

    // Push into a full TX FIFO in the same cycle as the FSM pops
    busy_force = 1'b1;
    do_reset();
    starts.delete();
    for (int i = 0; i < 4; i++) cpu_write(TXD, 32'(8'hC0 + i));
    cpu_read(CON, rd);
    check("tx_full_held", rd, 32'h08);
    busy_force = 1'b0;
    @(negedge sysclk);
    @(negedge sysclk);
    check("full_start_pulse", 32'(tx_start), 32'h1);
    cpu_write(TXD, 32'hC4);
    cpu_read(CON, rd);
    check("push_pop_full_no_ovf", rd, 32'h08);

    // RX bytes and interrupt
    do_reset();
    rx_push(8'h35);
    rx_push(8'h12);
    check("rx_irq_disabled", 32'(irq), 32'h0);
    cpu_write(CON, 32'h02);
    check("rx_irq_enabled", 32'(irq), 32'h1);
    cpu_read(CON, rd);
    check("rx_con", rd, 32'h16);
    cpu_read(RXD, rd);
    check("rx_read0", rd, 32'h35);
    check("rx_irq_after_first", 32'(irq), 32'h1);
    cpu_read(RXD, rd);
    check("rx_read1", rd, 32'h12);
    check("rx_irq_fall", 32'(irq), 32'h0);
    cpu_read(RXD, rd);
    check("rx_read_empty", rd, 32'h0);
    // Push and pop together on an empty FIFO
    rx_valid = 1'b1; rx_data = 8'h77;
    cpu_read(RXD, rd);
    rx_valid = 1'b0;
    check("rx_empty_pushpop_rd", rd, 32'h0);
    cpu_read(RXD, rd);
    check("rx_empty_pushpop_kept", rd, 32'h77);

    // RX full, simultaneous push+pop, then overrun
    do_reset();
    for (int i = 0; i < 4; i++) rx_push(8'(8'hA0 + i));
    rx_valid = 1'b1; rx_data = 8'hA4;
    cpu_read(RXD, rd);
    rx_valid = 1'b0;
    check("rx_full_pushpop_rd", rd, 32'hA0);
    cpu_read(CON, rd);
    check("rx_no_ovr", rd, 32'h14);
    rx_push(8'hA5);
    cpu_read(CON, rd);
    check("rx_ovr_set", rd, 32'h34);
    for (int i = 1; i <= 4; i++) begin
      cpu_read(RXD, rd);
      check("rx_order", rd, 32'(8'hA0 + i));
    end
    cpu_write(CON, 32'h20);
    cpu_read(CON, rd);
    check("rx_ovr_cleared", rd, 32'h10);

    // Reset while draining with three bytes queued
    do_reset();
    starts.delete();
    busy_len = 100;
    cpu_write(CON, 32'h03);
    rx_push(8'h99);
    for (int i = 0; i < 4; i++) cpu_write(TXD, 32'(8'hD0 + i));
    cpu_read(CON, rd);
    check("drain_con", rd, 32'h07);
    check("drain_irq", 32'(irq), 32'h1);
    reset = 1'b1;
    @(negedge sysclk);
    check("midreset_tx_start", 32'(tx_start), 32'h0);
    check("midreset_irq", 32'(irq), 32'h0);
    cpu_read(CON, rd);
    check("midreset_con", rd, 32'h10);
    reset = 1'b0;
    repeat (5) @(negedge sysclk);
    check("midreset_no_restart", 32'(starts.size()), 32'd1);
    cpu_read(RXD, rd);
    check("midreset_rx_flushed", rd, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
